bp_gshare_btb: RTL and testbench
================================

BP_GSHARE_BTB -- requirements
Module: bp_gshare_btb

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 32, number of direct-mapped BTB entries (power of two, >=2).
REQ-002 SHALL have parameter GHR_BITS, default 6, global history length; PHT depth = 2^GHR_BITS.
REQ-003 SHALL have parameter CTR_BITS, default 2, PHT saturating counter width (>=2).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have these ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pc_fetch  in  32  fetch-stage PC
- predicted_target  out  32  next-PC prediction
- branch_prediction  out  1  predict taken
- btb_hit  out  1  valid tag match for pc_fetch
- pht_idx_fetch  out  GHR_BITS  PHT index used for this lookup; pipelined to resolve stage
- update_en  in  1  resolved conditional branch this cycle
- update_pc  in  32  PC of resolved branch
- update_taken  in  1  actual outcome
- update_target  in  32  resolved taken target
- update_pht_idx  in  GHR_BITS  pht_idx_fetch captured at fetch of this branch
- update_mispredict  in  1  prediction was wrong
- ghr  out  GHR_BITS  current global history
- branch_count  out  32  resolved branches
- mispredict_count  out  32  resolved mispredictions

Function
REQ-006 SHALL derive IDX_W = log2(BTB_ENTRIES); btb index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
REQ-007 SHALL store per BTB entry: valid, tag, 32-bit target.
REQ-008 SHALL compute pht_idx_fetch = pc_fetch[GHR_BITS+1:2] XOR ghr, combinationally.
REQ-009 SHALL assert btb_hit combinationally when indexed entry is valid and tag equals pc_fetch tag.
REQ-010 SHALL assert branch_prediction = btb_hit AND MSB of PHT[pht_idx_fetch].
REQ-011 SHALL drive predicted_target = BTB target when branch_prediction=1, else pc_fetch+4 (mod 2^32).
REQ-012 SHALL, on update_en with update_taken=1, write BTB[update index] = {valid=1, update tag, update_target} at next edge.
REQ-013 SHALL leave BTB unchanged on update_en with update_taken=0 (no allocation, no invalidation).
REQ-014 SHALL, on update_en, increment PHT[update_pht_idx] if taken, decrement if not, saturating at 2^CTR_BITS-1 and 0.
REQ-015 SHALL, on update_en, shift ghr <= {ghr[GHR_BITS-2:0], update_taken}; no change otherwise.
REQ-016 SHALL, on update_en, increment branch_count, and mispredict_count if update_mispredict=1; both saturate at 0xFFFFFFFF.
REQ-017 SHALL ignore update_mispredict when update_en=0.
REQ-018 SHALL return pre-update contents for a fetch lookup in the same cycle as an update to the same BTB/PHT entry (write visible next cycle).
REQ-019 SHALL use pre-shift ghr for pht_idx_fetch in the cycle an update occurs.
REQ-020 SHALL have all storage updates take effect one clock after update_en sampled high; lookup latency zero cycles.

Reset
REQ-021 SHALL, while rst=1 at a clock edge, clear all BTB valid bits, set every PHT counter to 2^(CTR_BITS-1)-1 (weakly not-taken), clear ghr, branch_count, mispredict_count.
REQ-022 SHALL give rst priority over a simultaneous update_en; that update is discarded.
REQ-023 SHALL, after reset, output branch_prediction=0, btb_hit=0, predicted_target=pc_fetch+4.

Verification
REQ-024 SHALL pass: reset, pc_fetch=0x100 -> btb_hit=0, branch_prediction=0, predicted_target=0x104, pht_idx_fetch=0.
REQ-025 SHALL pass: update pc=0x100 taken target=0x200 pht_idx=0 -> next cycle ghr=0b000001, fetch 0x100 btb_hit=1, pht_idx_fetch=1, PHT[1]=01 so prediction 0, target 0x104; PHT[0]=10.
REQ-026 SHALL pass: four taken updates at pht_idx=5 -> PHT[5]=11; one not-taken -> 10, still predicts taken; four more not-taken -> 00, stays 00.
REQ-027 SHALL pass: BTB holds 0x100 (taken), fetch 0x180 (same index, different tag) -> btb_hit=0, target 0x184.
REQ-028 SHALL pass: update 0x100 taken target 0x300 while fetching 0x100 same cycle -> that cycle old target/state, next cycle target 0x300.
REQ-029 SHALL pass: 3 updates (1 mispredict) then rst together with update_en -> after edge branch_count=0, mispredict_count=0, ghr=0, btb_hit=0.

Source files
------------

// File: rtl/bp_gshare_btb.sv
// Gshare direction predictor combined with a direct-mapped branch target buffer.
// Lookups are combinational; every storage update lands on the clock edge after update_en.
module bp_gshare_btb #(
    parameter int BTB_ENTRIES = 32,
    parameter int GHR_BITS    = 6,
    parameter int CTR_BITS    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc_fetch,
    output logic [31:0]         predicted_target,
    output logic                branch_prediction,
    output logic                btb_hit,
    output logic [GHR_BITS-1:0] pht_idx_fetch,
    input  logic                update_en,
    input  logic [31:0]         update_pc,
    input  logic                update_taken,
    input  logic [31:0]         update_target,
    input  logic [GHR_BITS-1:0] update_pht_idx,
    input  logic                update_mispredict,
    output logic [GHR_BITS-1:0] ghr,
    output logic [31:0]         branch_count,
    output logic [31:0]         mispredict_count
);

    localparam int IDX_W     = $clog2(BTB_ENTRIES);
    localparam int TAG_W     = 30 - IDX_W;
    localparam int PHT_DEPTH = 1 << GHR_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;

    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
    logic [31:0]            btb_target_q [BTB_ENTRIES];
    logic [CTR_BITS-1:0]    pht_q        [PHT_DEPTH];
    logic [GHR_BITS-1:0]    ghr_q;
    logic [31:0]            branch_count_q;
    logic [31:0]            mispredict_count_q;

    logic [IDX_W-1:0]    fetch_idx;
    logic [TAG_W-1:0]    fetch_tag;
    logic [IDX_W-1:0]    upd_idx;
    logic [TAG_W-1:0]    upd_tag;
    logic [CTR_BITS-1:0] fetch_ctr;
    logic [CTR_BITS-1:0] upd_ctr;
    logic [CTR_BITS-1:0] upd_ctr_d;
    logic [31:0]         branch_count_d;
    logic [31:0]         mispredict_count_d;
    logic                unused_update_pc_lsbs;

    assign fetch_idx = pc_fetch[IDX_W+1:2];
    assign fetch_tag = pc_fetch[31:IDX_W+2];
    assign upd_idx   = update_pc[IDX_W+1:2];
    assign upd_tag   = update_pc[31:IDX_W+2];
    // Instructions are word aligned, so the byte offset of the update PC carries no information.
    assign unused_update_pc_lsbs = ^update_pc[1:0];

    assign pht_idx_fetch     = pc_fetch[GHR_BITS+1:2] ^ ghr_q;
    assign fetch_ctr         = pht_q[pht_idx_fetch];
    assign btb_hit           = btb_valid_q[fetch_idx] && (btb_tag_q[fetch_idx] == fetch_tag);
    assign branch_prediction = btb_hit && fetch_ctr[CTR_BITS-1];
    assign predicted_target  = branch_prediction ? btb_target_q[fetch_idx] : pc_fetch + 32'd4;

    assign ghr              = ghr_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

    // NOTE: every always_comb output gets a default on its first line so no path can infer a latch.
    always_comb begin
        upd_ctr_d          = upd_ctr;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (update_taken && upd_ctr != CTR_MAX) begin
            upd_ctr_d = upd_ctr + 1'b1;
        end else if (!update_taken && upd_ctr != CTR_MIN) begin
            upd_ctr_d = upd_ctr - 1'b1;
        end
        if (branch_count_q != 32'hFFFF_FFFF) begin
            branch_count_d = branch_count_q + 32'd1;
        end
        if (update_mispredict && mispredict_count_q != 32'hFFFF_FFFF) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    assign upd_ctr = pht_q[update_pht_idx];

    // NOTE: sequential state uses non-blocking assignments so same-edge reads see pre-update values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q              <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            btb_valid_q        <= '0;
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht_q[i] <= CTR_INIT;
            end
        end else if (update_en) begin
            ghr_q                  <= {ghr_q[GHR_BITS-2:0], update_taken};
            branch_count_q         <= branch_count_d;
            mispredict_count_q     <= mispredict_count_d;
            pht_q[update_pht_idx]  <= upd_ctr_d;
            if (update_taken) begin
                btb_valid_q[upd_idx] <= 1'b1;
            end
        end
    end

    // NOTE: BTB tag/target storage has no reset; the valid bits alone decide whether it is meaningful.
    always_ff @(posedge clk) begin
        if (!rst && update_en && update_taken) begin
            btb_tag_q[upd_idx]    <= upd_tag;
            btb_target_q[upd_idx] <= update_target;
        end
    end

endmodule

// File: tb/tb_bp_gshare_btb.sv
// Directed bench for bp_gshare_btb: reset, allocation, counter saturation, aliasing,
// same-cycle update visibility and reset priority over a concurrent update.
module tb_bp_gshare_btb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_fetch;
    logic [31:0] predicted_target;
    logic        branch_prediction;
    logic        btb_hit;
    logic [5:0]  pht_idx_fetch;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic [5:0]  update_pht_idx;
    logic        update_mispredict;
    logic [5:0]  ghr;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bp_gshare_btb dut (
        .clk               (clk),
        .rst               (rst),
        .pc_fetch          (pc_fetch),
        .predicted_target  (predicted_target),
        .branch_prediction (branch_prediction),
        .btb_hit           (btb_hit),
        .pht_idx_fetch     (pht_idx_fetch),
        .update_en         (update_en),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_pht_idx    (update_pht_idx),
        .update_mispredict (update_mispredict),
        .ghr               (ghr),
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                                input logic [5:0] idx, input logic mis);
        update_en         = 1'b1;
        update_pc         = pc;
        update_taken      = taken;
        update_target     = target;
        update_pht_idx    = idx;
        update_mispredict = mis;
        step();
        update_en         = 1'b0;
        update_mispredict = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        pc_fetch = 32'h100;
        #1;
        checks++; if (btb_hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", btb_hit); end
        checks++; if (branch_prediction !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b exp=0", branch_prediction); end
        checks++; if (predicted_target !== 32'h104) begin failures++; $display("FAIL reset_target got=%h exp=104", predicted_target); end
        checks++; if (pht_idx_fetch !== 6'd0) begin failures++; $display("FAIL reset_pht_idx got=%0d exp=0", pht_idx_fetch); end
        checks++; if (ghr !== 6'd0) begin failures++; $display("FAIL reset_ghr got=%h exp=0", ghr); end
        checks++; if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
            failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", branch_count, mispredict_count); end
        checks++; if (dut.pht_q[0] !== 2'b01) begin failures++; $display("FAIL reset_pht0 got=%b exp=01", dut.pht_q[0]); end
    endtask

    task automatic test_first_update();
        pc_fetch = 32'h100;
        drive_update(32'h100, 1'b1, 32'h200, 6'd0, 1'b1);
        checks++; if (ghr !== 6'b000001) begin failures++; $display("FAIL first_ghr got=%b exp=000001", ghr); end
        checks++; if (btb_hit !== 1'b1) begin failures++; $display("FAIL first_hit got=%b exp=1", btb_hit); end
        checks++; if (pht_idx_fetch !== 6'd1) begin failures++; $display("FAIL first_pht_idx got=%0d exp=1", pht_idx_fetch); end
        checks++; if (branch_prediction !== 1'b0) begin failures++; $display("FAIL first_pred got=%b exp=0", branch_prediction); end
        checks++; if (predicted_target !== 32'h104) begin failures++; $display("FAIL first_target got=%h exp=104", predicted_target); end
        checks++; if (dut.pht_q[0] !== 2'b10) begin failures++; $display("FAIL first_pht0 got=%b exp=10", dut.pht_q[0]); end
        checks++; if (dut.pht_q[1] !== 2'b01) begin failures++; $display("FAIL first_pht1 got=%b exp=01", dut.pht_q[1]); end
        checks++; if (branch_count !== 32'd1 || mispredict_count !== 32'd1) begin
            failures++; $display("FAIL first_counts got=%0d/%0d exp=1/1", branch_count, mispredict_count); end
    endtask

    // 0xEC maps to BTB entry 27; with ghr=0x3E its PHT index is 0x3B^0x3E = 5.
    task automatic test_pht_saturation();
        for (int i = 0; i < 4; i++) drive_update(32'hEC, 1'b1, 32'h400, 6'd5, 1'b0);
        checks++; if (dut.pht_q[5] !== 2'b11) begin failures++; $display("FAIL sat_high got=%b exp=11", dut.pht_q[5]); end
        drive_update(32'hEC, 1'b0, 32'h400, 6'd5, 1'b0);
        checks++; if (dut.pht_q[5] !== 2'b10) begin failures++; $display("FAIL sat_dec got=%b exp=10", dut.pht_q[5]); end
        checks++; if (ghr !== 6'h3E) begin failures++; $display("FAIL sat_ghr1 got=%h exp=3e", ghr); end
        pc_fetch = 32'hEC;
        #1;
        checks++; if (pht_idx_fetch !== 6'd5) begin failures++; $display("FAIL sat_idx got=%0d exp=5", pht_idx_fetch); end
        checks++; if (branch_prediction !== 1'b1 || predicted_target !== 32'h400) begin
            failures++; $display("FAIL sat_pred got=%b/%h exp=1/400", branch_prediction, predicted_target); end
        for (int i = 0; i < 4; i++) drive_update(32'hEC, 1'b0, 32'h999, 6'd5, 1'b0);
        checks++; if (dut.pht_q[5] !== 2'b00) begin failures++; $display("FAIL sat_low got=%b exp=00", dut.pht_q[5]); end
        checks++; if (ghr !== 6'h20) begin failures++; $display("FAIL sat_ghr2 got=%h exp=20", ghr); end
        checks++; if (btb_hit !== 1'b1) begin failures++; $display("FAIL sat_not_taken_keeps_btb got=%b exp=1", btb_hit); end
        checks++; if (branch_prediction !== 1'b0 || predicted_target !== 32'hF0) begin
            failures++; $display("FAIL sat_fallthrough got=%b/%h exp=0/f0", branch_prediction, predicted_target); end
        checks++; if (branch_count !== 32'd10) begin failures++; $display("FAIL sat_count got=%0d exp=10", branch_count); end
    endtask

    task automatic test_alias_and_idle();
        pc_fetch = 32'h180;
        #1;
        checks++; if (btb_hit !== 1'b0 || predicted_target !== 32'h184) begin
            failures++; $display("FAIL alias got=%b/%h exp=0/184", btb_hit, predicted_target); end
        update_en = 1'b0;
        update_mispredict = 1'b1;
        update_taken = 1'b1;
        update_pc = 32'h180;
        step();
        update_mispredict = 1'b0;
        #1;
        checks++; if (branch_count !== 32'd10 || mispredict_count !== 32'd1 || ghr !== 6'h20) begin
            failures++; $display("FAIL idle got=%0d/%0d/%h exp=10/1/20", branch_count, mispredict_count, ghr); end
        checks++; if (btb_hit !== 1'b0) begin failures++; $display("FAIL idle_no_alloc got=%b exp=0", btb_hit); end
    endtask

    task automatic test_same_cycle_update();
        for (int i = 0; i < 6; i++) drive_update(32'hEC, 1'b1, 32'h400, 6'd63, 1'b0);
        checks++; if (ghr !== 6'h3F || dut.pht_q[63] !== 2'b11) begin
            failures++; $display("FAIL same_setup got=%h/%b exp=3f/11", ghr, dut.pht_q[63]); end
        pc_fetch = 32'h100;
        update_en = 1'b1;
        update_pc = 32'h100;
        update_taken = 1'b1;
        update_target = 32'h300;
        update_pht_idx = 6'd63;
        update_mispredict = 1'b0;
        #1;
        checks++; if (pht_idx_fetch !== 6'd63 || btb_hit !== 1'b1) begin
            failures++; $display("FAIL same_lookup got=%0d/%b exp=63/1", pht_idx_fetch, btb_hit); end
        checks++; if (branch_prediction !== 1'b1 || predicted_target !== 32'h200) begin
            failures++; $display("FAIL same_old_target got=%b/%h exp=1/200", branch_prediction, predicted_target); end
        step();
        update_en = 1'b0;
        #1;
        checks++; if (branch_prediction !== 1'b1 || predicted_target !== 32'h300) begin
            failures++; $display("FAIL same_new_target got=%b/%h exp=1/300", branch_prediction, predicted_target); end
        checks++; if (branch_count !== 32'd17) begin failures++; $display("FAIL same_count got=%0d exp=17", branch_count); end
    endtask

    task automatic test_reset_priority();
        drive_update(32'h100, 1'b1, 32'h300, 6'd0, 1'b1);
        drive_update(32'h100, 1'b0, 32'h0, 6'd1, 1'b0);
        drive_update(32'hEC, 1'b1, 32'h400, 6'd2, 1'b0);
        checks++; if (branch_count !== 32'd20 || mispredict_count !== 32'd2) begin
            failures++; $display("FAIL prio_pre got=%0d/%0d exp=20/2", branch_count, mispredict_count); end
        rst = 1'b1;
        update_en = 1'b1;
        update_pc = 32'h180;
        update_taken = 1'b1;
        update_target = 32'h500;
        update_pht_idx = 6'd0;
        update_mispredict = 1'b1;
        step();
        rst = 1'b0;
        update_en = 1'b0;
        update_mispredict = 1'b0;
        pc_fetch = 32'h100;
        #1;
        checks++; if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
            failures++; $display("FAIL prio_counts got=%0d/%0d exp=0/0", branch_count, mispredict_count); end
        checks++; if (ghr !== 6'd0) begin failures++; $display("FAIL prio_ghr got=%h exp=0", ghr); end
        checks++; if (btb_hit !== 1'b0 || predicted_target !== 32'h104) begin
            failures++; $display("FAIL prio_btb got=%b/%h exp=0/104", btb_hit, predicted_target); end
        checks++; if (dut.pht_q[0] !== 2'b01) begin failures++; $display("FAIL prio_pht0 got=%b exp=01", dut.pht_q[0]); end
        pc_fetch = 32'h180;
        #1;
        checks++; if (btb_hit !== 1'b0) begin failures++; $display("FAIL prio_discarded got=%b exp=0", btb_hit); end
    endtask

    initial begin
        rst               = 1'b1;
        pc_fetch          = 32'h100;
        update_en         = 1'b0;
        update_pc         = 32'h0;
        update_taken      = 1'b0;
        update_target     = 32'h0;
        update_pht_idx    = 6'd0;
        update_mispredict = 1'b0;
        test_reset();
        test_first_update();
        test_pht_saturation();
        test_alias_and_idle();
        test_same_cycle_update();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
